// File: rtl/vga_timing_gen_pkg.sv
// 640x480@60 Hz raster constants and helpers shared by the VGA timing generator.
// Derived totals and sync windows follow from the porch and sync widths.
package vga_timing_gen_pkg;

    localparam int unsigned ClkDiv  = 4;
    localparam int unsigned HActive = 640;
    localparam int unsigned HFp     = 16;
    localparam int unsigned HSync   = 96;
    localparam int unsigned HBp     = 48;
    localparam int unsigned VActive = 480;
    localparam int unsigned VFp     = 10;
    localparam int unsigned VSync   = 2;
    localparam int unsigned VBp     = 33;
    localparam bit          SyncPol = 1'b0;

    localparam int unsigned HTotal     = HActive + HFp + HSync + HBp;
    localparam int unsigned VTotal     = VActive + VFp + VSync + VBp;
    localparam int unsigned HSyncStart = HActive + HFp;
    localparam int unsigned HSyncEnd   = HActive + HFp + HSync;
    localparam int unsigned VSyncStart = VActive + VFp;
    localparam int unsigned VSyncEnd   = VActive + VFp + VSync;

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 10;

    // Map a logical "in sync window" flag onto the connector level.
    function automatic logic sync_level(logic active, logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel generator and connector.
interface vga_timing_gen_if;

    logic                                p_tick;
    logic [vga_timing_gen_pkg::X_W-1:0]  x;
    logic [vga_timing_gen_pkg::Y_W-1:0]  y;
    logic                                video_on;
    logic                                hsync;
    logic                                vsync;
    logic                                frame_tick;

    modport master (
        output p_tick, x, y, video_on, hsync, vsync, frame_tick
    );

    modport slave (
        input p_tick, x, y, video_on, hsync, vsync, frame_tick
    );

endinterface

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Pixel-rate divider: free-running modulo-CLK_DIV counter with a registered one-clk tick.
module vga_timing_gen_pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick_o,
    output logic p_tick_next_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            p_tick_q, p_tick_d;

    // The tick is registered off the terminal count, so it rises on the edge that wraps
    // the counter; with CLK_DIV=1 it stays high from the first clk out of reset.
    always_comb begin
        div_cnt_d = (div_cnt_q == CntLast) ? '0 : div_cnt_q + CntW'(1);
        p_tick_d  = (div_cnt_q == CntLast);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            p_tick_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            p_tick_q  <= p_tick_d;
        end
    end

    assign p_tick_o      = p_tick_q;
    assign p_tick_next_o = reset ? 1'b0 : p_tick_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel tick, x/y scan counters and registered sync/blank decode.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV  = vga_timing_gen_pkg::ClkDiv,
    parameter int unsigned H_ACTIVE = vga_timing_gen_pkg::HActive,
    parameter int unsigned H_FP     = vga_timing_gen_pkg::HFp,
    parameter int unsigned H_SYNC   = vga_timing_gen_pkg::HSync,
    parameter int unsigned H_BP     = vga_timing_gen_pkg::HBp,
    parameter int unsigned V_ACTIVE = vga_timing_gen_pkg::VActive,
    parameter int unsigned V_FP     = vga_timing_gen_pkg::VFp,
    parameter int unsigned V_SYNC   = vga_timing_gen_pkg::VSync,
    parameter int unsigned V_BP     = vga_timing_gen_pkg::VBp,
    parameter bit          SYNC_POL = vga_timing_gen_pkg::SyncPol
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] XLast      = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] XActive    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] XSyncStart = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] XSyncEnd   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] YLast      = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] YActive    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] YSyncStart = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] YSyncEnd   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic           p_tick, p_tick_next;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           video_on_q, video_on_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           frame_tick_q, frame_tick_d;

    vga_timing_gen_pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .clk           (clk),
        .reset         (reset),
        .p_tick_o      (p_tick),
        .p_tick_next_o (p_tick_next)
    );

    // Decode is taken from next-state x/y so the registered flags line up with x/y.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick) begin
            if (x_q == XLast) begin
                x_d = '0;
                y_d = (y_q == YLast) ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
        video_on_d   = (x_d < XActive) && (y_d < YActive);
        hsync_d      = sync_level((x_d >= XSyncStart) && (x_d < XSyncEnd), SYNC_POL);
        vsync_d      = sync_level((y_d >= YSyncStart) && (y_d < YSyncEnd), SYNC_POL);
        frame_tick_d = p_tick_next && (x_d == XLast) && (y_d == YLast);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            video_on_q   <= 1'b0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            frame_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            video_on_q   <= video_on_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga_o.p_tick     = p_tick;
    assign vga_o.x          = x_q;
    assign vga_o.y          = y_q;
    assign vga_o.video_on   = video_on_q;
    assign vga_o.hsync      = hsync_q;
    assign vga_o.vsync      = vsync_q;
    assign vga_o.frame_tick = frame_tick_q;

endmodule
